// File: rtl/pwm_peripheral_pkg.sv
// Shared constants for the 16-channel PWM peripheral.
package pwm_peripheral_pkg;
  localparam int PWM_BITS = 8;
  localparam int CLK_DIV_DEFAULT = 13;
  localparam int PRE_W = 16;
  localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;
  localparam logic [PWM_BITS-1:0] CNT_LAST = 8'hFF;
endpackage

// File: rtl/pwm_peripheral_counter.sv
// Prescaler plus PWM step counter; wrap marks the last step of a period.
module pwm_counter
  import pwm_peripheral_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int CNT_W = pwm_peripheral_pkg::PWM_BITS
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] pwm_cnt,
  output logic             tick,
  output logic             wrap
);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = (pre_cnt == PRE_LAST);
  assign wrap = tick && (pwm_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral: shared counter, period-shadowed duty, registered outputs.
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int PWM_BITS = pwm_peripheral_pkg::PWM_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       period_start
);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                wrap;
  logic                first;
  logic                wrap_p1;
  logic                load_duty;
  logic [PWM_BITS-1:0] duty_shadow;
  logic [PWM_BITS-1:0] duty_eff;
  logic                pwm_sig;
  logic [15:0]         en_out;
  logic [15:0]         en_pwm;
  logic [15:0]         out_next;
  logic [15:0]         out_p1;

  function automatic logic pwm_level(input logic [PWM_BITS-1:0] cnt,
                                     input logic [PWM_BITS-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

  pwm_counter #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (PWM_BITS)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .pwm_cnt(pwm_cnt),
    .tick   (tick),
    .wrap   (wrap)
  );

  // The first cycle after reset loads the shadow; bypass it so that cycle already uses the new duty.
  assign load_duty = first | (tick & (pwm_cnt == CNT_LAST));
  assign duty_eff  = first ? pwm_duty_cycle : duty_shadow;
  assign pwm_sig   = pwm_level(pwm_cnt, duty_eff);
  assign en_out    = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign out_next  = en_out & (~en_pwm | {16{pwm_sig}});

  // Stage p1: registered outputs; period_start aligns with the first pwm_cnt==0 output cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      first        <= 1'b1;
      wrap_p1      <= 1'b0;
      duty_shadow  <= '0;
      out_p1       <= '0;
      period_start <= 1'b0;
    end else begin
      first        <= 1'b0;
      wrap_p1      <= wrap;
      if (load_duty) duty_shadow <= pwm_duty_cycle;
      out_p1       <= out_next;
      period_start <= first | wrap_p1;
    end
  end

  assign out_7_0  = out_p1[7:0];
  assign out_15_8 = out_p1[15:8];
endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with CLK_DIV=2 (512-cycle period).
module tb_pwm_peripheral;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;
  logic [7:0]  out_7_0;
  logic [7:0]  out_15_8;
  logic        period_start;

  int n_total = 0;
  int n_pass = 0;
  bit done = 1'b0;

  pwm_peripheral #(.CLK_DIV(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_reg_out_7_0 (en_out[7:0]),
    .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0 (en_pwm[7:0]),
    .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle (duty),
    .out_7_0        (out_7_0),
    .out_15_8       (out_15_8),
    .period_start   (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  duty;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    int          off;
    logic [15:0] exp_out;
    logic        exp_ps;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Inputs change only at negedges; outputs are sampled at negedges before any change.
  task automatic start_run(input logic [7:0] d, input logic [15:0] eo, input logic [15:0] ep,
                           input bit check_reset);
    rst = 1'b1;
    duty = d;
    en_out = eo;
    en_pwm = ep;
    @(negedge clk);
    @(negedge clk);
    if (check_reset) begin
      chk("reset_out", {out_15_8, out_7_0}, 16'h0000);
      chk("reset_ps", period_start, 1'b0);
    end
    rst = 1'b0;
  endtask

  task automatic wait_ps(input string name);
    int n;
    @(negedge clk);
    n = 1;
    while (period_start !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk(name, period_start, 1'b1);
  endtask

  // Counts full-on cycles over one period starting at the current (offset 0) negedge.
  task automatic run_period(input int chg_at, input logic [7:0] new_duty, output int highs);
    highs = 0;
    for (int i = 0; i < 512; i++) begin
      if ({out_15_8, out_7_0} === 16'hFFFF) highs++;
      if (i == chg_at) duty = new_duty;
      @(negedge clk);
    end
  endtask

  initial begin
    int highs;
    vecs[0]  = '{8'd128, 16'hFFFF, 16'hFFFF,   0, 16'hFFFF, 1'b1};
    vecs[1]  = '{8'd128, 16'hFFFF, 16'hFFFF, 255, 16'hFFFF, 1'b0};
    vecs[2]  = '{8'd128, 16'hFFFF, 16'hFFFF, 256, 16'h0000, 1'b0};
    vecs[3]  = '{8'd128, 16'hFFFF, 16'hFFFF, 511, 16'h0000, 1'b0};
    vecs[4]  = '{8'd128, 16'hFFFF, 16'hFFFF, 512, 16'hFFFF, 1'b1};
    vecs[5]  = '{8'd0,   16'hFFFF, 16'hFFFF,   0, 16'h0000, 1'b1};
    vecs[6]  = '{8'd0,   16'hFFFF, 16'hFFFF, 300, 16'h0000, 1'b0};
    vecs[7]  = '{8'd255, 16'hFFFF, 16'hFFFF, 509, 16'hFFFF, 1'b0};
    vecs[8]  = '{8'd255, 16'hFFFF, 16'hFFFF, 510, 16'hFFFF, 1'b0};
    vecs[9]  = '{8'd1,   16'hFFFF, 16'hFFFF,   1, 16'hFFFF, 1'b0};
    vecs[10] = '{8'd1,   16'hFFFF, 16'hFFFF,   2, 16'h0000, 1'b0};
    vecs[11] = '{8'd254, 16'hFFFF, 16'hFFFF, 507, 16'hFFFF, 1'b0};
    vecs[12] = '{8'd254, 16'hFFFF, 16'hFFFF, 508, 16'h0000, 1'b0};
    vecs[13] = '{8'd64,  16'h00FF, 16'h000F,  10, 16'h00FF, 1'b0};
    vecs[14] = '{8'd64,  16'h00FF, 16'h000F, 200, 16'h00F0, 1'b0};
    vecs[15] = '{8'd64,  16'h00FF, 16'h000F, 127, 16'h00FF, 1'b0};
    vecs[16] = '{8'd64,  16'h00FF, 16'h000F, 128, 16'h00F0, 1'b0};
    vecs[17] = '{8'd0,   16'hFFFF, 16'h0000,   5, 16'hFFFF, 1'b0};
    vecs[18] = '{8'd200, 16'h0000, 16'hFFFF,   5, 16'h0000, 1'b0};
    vecs[19] = '{8'd100, 16'hA5C3, 16'hFF00, 150, 16'hA5C3, 1'b0};

    for (int v = 0; v < 20; v++) begin
      start_run(vecs[v].duty, vecs[v].en_out, vecs[v].en_pwm, v == 0);
      wait_ps($sformatf("v%0d_start", v));
      repeat (vecs[v].off) @(negedge clk);
      chk($sformatf("v%0d_out", v), {out_15_8, out_7_0}, vecs[v].exp_out);
      chk($sformatf("v%0d_ps", v), period_start, vecs[v].exp_ps);
    end

    // Duty 64 -> 192 mid-period: current period keeps 64 steps.
    start_run(8'd64, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_ps("chg_start");
    run_period(10, 8'd192, highs);
    chk("chg_cur_highs", highs, 128);
    chk("chg_ps_512", period_start, 1'b1);
    run_period(-1, 8'd0, highs);
    chk("chg_next_highs", highs, 384);
    chk("chg_ps_1024", period_start, 1'b1);

    // Duty 0 then 255: no glitch in either direction.
    start_run(8'd0, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_ps("full_start");
    run_period(100, 8'd255, highs);
    chk("zero_highs", highs, 0);
    run_period(-1, 8'd0, highs);
    chk("full_highs", highs, 512);

    // Enable toggle on channel 8 during the low phase.
    start_run(8'd64, 16'h00FF, 16'h000F, 1'b0);
    wait_ps("en_start");
    repeat (200) @(negedge clk);
    chk("en8_before", out_15_8, 8'h00);
    en_out[8] = 1'b1;
    @(negedge clk);
    chk("en8_on", out_15_8, 8'h01);
    en_out[8] = 1'b0;
    @(negedge clk);
    chk("en8_off", out_15_8, 8'h00);

    // Reset pulse at pwm_cnt=100, then restart with a reloaded duty.
    start_run(8'd64, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_ps("rst_start");
    repeat (199) @(negedge clk);
    rst = 1'b1;
    duty = 8'd10;
    @(negedge clk);
    chk("rst_out", {out_15_8, out_7_0}, 16'h0000);
    chk("rst_ps", period_start, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_restart_ps", period_start, 1'b1);
    chk("rst_restart_out", {out_15_8, out_7_0}, 16'hFFFF);
    run_period(-1, 8'd10, highs);
    chk("rst_reload_highs", highs, 20);
    chk("rst_ps_512", period_start, 1'b1);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
    end
  end
endmodule
